// File: rtl/regfile_ptr_pkg.sv
// Shared tinySoC definitions: default register count and the pointer-operation
// encoding used between the register file and its incrementer.
package tinysoc_pkg;

  localparam int REG_COUNT_DEFAULT = 16;

  typedef enum logic [1:0] {
    PTR_NOP,
    PTR_INC,
    PTR_DEC
  } ptr_op_e;

  // inc and dec together cancel out, so only a lone strobe is a real operation
  function automatic ptr_op_e decode_ptr_op(input logic inc, input logic dec);
    if (inc && !dec) return PTR_INC;
    if (dec && !inc) return PTR_DEC;
    return PTR_NOP;
  endfunction

endpackage

// File: rtl/regfile_ptr_if.sv
// Bus bundle for the register file: write port, two read ports and the
// pointer port. The datapath drives it as master, the register file is slave.
interface regfile_ptr_if
  import tinysoc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = REG_COUNT_DEFAULT
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (AW > 1) ? AW - 1 : 1;

  logic [AW-1:0]      in_select;
  logic [WIDTH-1:0]   in_data;
  logic               write_en;
  logic [AW-1:0]      out_a_select;
  logic [AW-1:0]      out_b_select;
  logic [WIDTH-1:0]   out_a;
  logic [WIDTH-1:0]   out_b;
  logic [PW-1:0]      inc_select;
  logic               inc;
  logic               dec;
  logic [2*WIDTH-1:0] out_c;
  logic               wrap;

  modport master (
    output in_select, in_data, write_en, out_a_select, out_b_select,
    output inc_select, inc, dec,
    input  out_a, out_b, out_c, wrap
  );

  modport slave (
    input  in_select, in_data, write_en, out_a_select, out_b_select,
    input  inc_select, inc, dec,
    output out_a, out_b, out_c, wrap
  );

endinterface

// File: rtl/regfile_ptr_incdec.sv
// Combinational +1/-1 on a full register pair, flagging the all-ones to zero
// (or zero to all-ones) transition as a wrap.
module ptr_incdec
  import tinysoc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  input  ptr_op_e      op_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  always_comb begin
    value_o = value_i;
    wrap_o  = 1'b0;
    unique case (op_i)
      PTR_INC: begin
        value_o = value_i + W'(1);
        wrap_o  = &value_i;
      end
      PTR_DEC: begin
        value_o = value_i - W'(1);
        wrap_o  = ~|value_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_ptr.sv
// General-purpose register file with two combinational read ports, one write
// port and a pointer port that steps an adjacent register pair as one value.
module regfile_ptr
  import tinysoc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = REG_COUNT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  regfile_ptr_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];
  logic               wrap_q;
  logic               wrap_d;

  ptr_op_e            ptrOp;
  logic [AW-1:0]      loIdx;
  logic [AW-1:0]      hiIdx;
  logic [2*WIDTH-1:0] pairValue;
  logic [2*WIDTH-1:0] pairNext;
  logic               pairWrap;
  logic               writeHitsPair;
  logic               ptrActive;

  // pair p lives in registers 2p (low half) and 2p+1 (high half)
  assign loIdx     = AW'({bus.inc_select, 1'b0});
  assign hiIdx     = loIdx | AW'(1);
  assign pairValue = {regs_q[hiIdx], regs_q[loIdx]};
  assign ptrOp     = decode_ptr_op(bus.inc, bus.dec);

  assign writeHitsPair = bus.write_en && ((bus.in_select | AW'(1)) == hiIdx);
  assign ptrActive     = (ptrOp != PTR_NOP) && !writeHitsPair;

  ptr_incdec #(
    .W(2 * WIDTH)
  ) u_incdec (
    .value_i (pairValue),
    .op_i    (ptrOp),
    .value_o (pairNext),
    .wrap_o  (pairWrap)
  );

  assign bus.out_a = regs_q[bus.out_a_select];
  assign bus.out_b = regs_q[bus.out_b_select];
  assign bus.out_c = pairValue;
  assign bus.wrap  = wrap_q;

  // a write into the selected pair cancels the whole pointer step, wrap included
  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    if (ptrActive) begin
      regs_d[loIdx] = pairNext[WIDTH-1:0];
      regs_d[hiIdx] = pairNext[2*WIDTH-1:WIDTH];
      wrap_d        = pairWrap;
    end
    if (bus.write_en) begin
      regs_d[bus.in_select] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_regfile_ptr.sv
// Self-checking bench for regfile_ptr: directed vector table, hand-written
// corner sequences, a narrow instance, and random traffic against a model.
module tb_regfile_ptr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_ptr_if #(.WIDTH(8), .DEPTH(16)) bus8 ();
  regfile_ptr_if #(.WIDTH(4), .DEPTH(4))  bus4 ();

  regfile_ptr #(.WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  regfile_ptr #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  data;
    logic        inc;
    logic        dec;
    logic [2:0]  isel;
    logic [3:0]  asel;
    logic [3:0]  bsel;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [15:0] expC;
    logic        expWrap;
  } vec_t;

  vec_t vecs[20];

  // reference model state for the random phase
  int modelReg[16];
  int modelWrap;

  function automatic vec_t mkVec(input logic r, input logic we, input int sel, input int data,
                                 input logic inc, input logic dec, input int isel,
                                 input int asel, input int bsel,
                                 input int expA, input int expB, input int expC,
                                 input logic expWrap);
    vec_t v;
    v.rst = r;  v.we = we;  v.sel = 4'(sel);  v.data = 8'(data);
    v.inc = inc;  v.dec = dec;  v.isel = 3'(isel);
    v.asel = 4'(asel);  v.bsel = 4'(bsel);
    v.expA = 8'(expA);  v.expB = 8'(expB);  v.expC = 16'(expC);
    v.expWrap = expWrap;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    bus8.write_en = 1'b0;  bus8.in_select = '0;  bus8.in_data = '0;
    bus8.inc = 1'b0;  bus8.dec = 1'b0;  bus8.inc_select = '0;
    bus8.out_a_select = '0;  bus8.out_b_select = '0;
  endtask

  task automatic idle4();
    bus4.write_en = 1'b0;  bus4.in_select = '0;  bus4.in_data = '0;
    bus4.inc = 1'b0;  bus4.dec = 1'b0;  bus4.inc_select = '0;
    bus4.out_a_select = '0;  bus4.out_b_select = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst               = v.rst;
    bus8.write_en     = v.we;
    bus8.in_select    = v.sel;
    bus8.in_data      = v.data;
    bus8.inc          = v.inc;
    bus8.dec          = v.dec;
    bus8.inc_select   = v.isel;
    bus8.out_a_select = v.asel;
    bus8.out_b_select = v.bsel;
    tick();
  endtask

  // pair arithmetic done on whole 16-bit integers, then split back into bytes
  task automatic modelEdge(input logic r, input logic we, input int sel, input int data,
                           input logic inc, input logic dec, input int isel);
    int pv;
    int nv;
    int nextWrap;
    nextWrap = 0;
    if (r) begin
      foreach (modelReg[i]) modelReg[i] = 0;
      modelWrap = 0;
      return;
    end
    pv = modelReg[2*isel+1] * 256 + modelReg[2*isel];
    if ((inc != dec) && !(we && (sel / 2 == isel))) begin
      if (inc) begin
        nv = (pv + 1) % 65536;
        nextWrap = (pv == 65535) ? 1 : 0;
      end else begin
        nv = (pv + 65535) % 65536;
        nextWrap = (pv == 0) ? 1 : 0;
      end
      modelReg[2*isel]   = nv % 256;
      modelReg[2*isel+1] = nv / 256;
    end
    if (we) modelReg[sel] = data;
    modelWrap = nextWrap;
  endtask

  initial begin
    idle8();
    idle4();

    //              rst we sel data inc dec isel asel bsel  expA  expB  expC    wrap
    vecs[0]  = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 0);
    vecs[1]  = mkVec(0, 1, 3, 8'hA5, 0, 0, 0, 3, 7, 8'hA5, 8'h00, 16'h0000, 0);
    vecs[2]  = mkVec(0, 1, 7, 8'h5A, 0, 0, 0, 3, 7, 8'hA5, 8'h5A, 16'h0000, 0);
    vecs[3]  = mkVec(0, 1, 3, 8'h00, 0, 0, 1, 2, 3, 8'h00, 8'h00, 16'h0000, 0);
    vecs[4]  = mkVec(0, 1, 2, 8'hFF, 0, 0, 1, 2, 3, 8'hFF, 8'h00, 16'h00FF, 0);
    vecs[5]  = mkVec(0, 0, 0, 8'h00, 1, 0, 1, 2, 3, 8'h00, 8'h01, 16'h0100, 0);
    vecs[6]  = mkVec(0, 0, 0, 8'h00, 0, 1, 1, 2, 3, 8'hFF, 8'h00, 16'h00FF, 0);
    vecs[7]  = mkVec(0, 0, 0, 8'h00, 0, 1, 1, 2, 3, 8'hFE, 8'h00, 16'h00FE, 0);
    vecs[8]  = mkVec(0, 1, 0, 8'hFF, 0, 0, 0, 0, 1, 8'hFF, 8'h00, 16'h00FF, 0);
    vecs[9]  = mkVec(0, 1, 1, 8'hFF, 0, 0, 0, 0, 1, 8'hFF, 8'hFF, 16'hFFFF, 0);
    vecs[10] = mkVec(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 1);
    vecs[11] = mkVec(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hFF, 8'hFF, 16'hFFFF, 1);
    vecs[12] = mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'hFF, 8'hFF, 16'hFFFF, 0);
    vecs[13] = mkVec(0, 1, 4, 8'h34, 0, 0, 2, 4, 5, 8'h34, 8'h00, 16'h0034, 0);
    vecs[14] = mkVec(0, 1, 5, 8'h12, 0, 0, 2, 4, 5, 8'h34, 8'h12, 16'h1234, 0);
    vecs[15] = mkVec(0, 1, 4, 8'h77, 1, 0, 2, 4, 5, 8'h77, 8'h12, 16'h1277, 0);
    vecs[16] = mkVec(0, 1, 4, 8'h34, 0, 0, 2, 4, 5, 8'h34, 8'h12, 16'h1234, 0);
    vecs[17] = mkVec(0, 1, 9, 8'h77, 1, 0, 2, 9, 4, 8'h77, 8'h35, 16'h1235, 0);
    vecs[18] = mkVec(0, 1, 1, 8'h00, 1, 0, 0, 0, 1, 8'hFF, 8'h00, 16'h00FF, 0);
    vecs[19] = mkVec(0, 0, 0, 8'h00, 0, 0, 1, 3, 7, 8'h00, 8'h5A, 16'h00FE, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d out_a", i), 32'(bus8.out_a), 32'(vecs[i].expA));
      checkOutput($sformatf("vec%0d out_b", i), 32'(bus8.out_b), 32'(vecs[i].expB));
      checkOutput($sformatf("vec%0d out_c", i), 32'(bus8.out_c), 32'(vecs[i].expC));
      checkOutput($sformatf("vec%0d wrap", i),  32'(bus8.wrap),  32'(vecs[i].expWrap));
    end

    // write is not visible on a read port until after the edge
    idle8();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus8.write_en = 1'b1;  bus8.in_select = 4'd3;  bus8.in_data = 8'hA5;
    bus8.out_a_select = 4'd3;
    #1;
    checkOutput("no bypass out_a", 32'(bus8.out_a), 32'h00);
    tick();
    checkOutput("write visible out_a", 32'(bus8.out_a), 32'hA5);

    // reset in the middle of an increment run, then resume from zero
    idle8();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus8.inc = 1'b1;
    tick();
    checkOutput("mid-reset first inc", 32'(bus8.out_c), 32'h0001);
    rst = 1'b1;
    tick();
    checkOutput("mid-reset cleared", 32'(bus8.out_c), 32'h0000);
    checkOutput("mid-reset wrap", 32'(bus8.wrap), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("mid-reset resume", 32'(bus8.out_c), 32'h0001);
    idle8();

    // narrow instance: 4-bit registers, two pairs
    bus4.write_en = 1'b1;  bus4.in_select = 2'd2;  bus4.in_data = 4'hF;
    tick();
    bus4.in_select = 2'd3;
    tick();
    bus4.write_en = 1'b0;  bus4.inc_select = 1'b1;
    #1;
    checkOutput("w4 pair preset", 32'(bus4.out_c), 32'hFF);
    bus4.inc = 1'b1;
    tick();
    checkOutput("w4 inc wrap value", 32'(bus4.out_c), 32'h00);
    checkOutput("w4 inc wrap flag", 32'(bus4.wrap), 32'h1);
    bus4.inc = 1'b0;
    tick();
    checkOutput("w4 wrap clears", 32'(bus4.wrap), 32'h0);
    bus4.write_en = 1'b1;  bus4.in_select = 2'd3;  bus4.in_data = 4'hA;
    bus4.out_b_select = 2'd3;
    tick();
    checkOutput("w4 top reg out_b", 32'(bus4.out_b), 32'hA);
    idle4();

    // random traffic against the reference model
    rst = 1'b1;
    tick();
    modelEdge(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      int pick;
      int sel;
      int data;
      int isel;
      pick = int'($urandom_range(0, 3));
      data = (pick == 0) ? 8'hFF : (pick == 1) ? 8'h00 : int'($urandom_range(0, 255));
      sel  = int'($urandom_range(0, 15));
      isel = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
      rst               = ($urandom_range(0, 39) == 0);
      bus8.write_en     = ($urandom_range(0, 2) == 0);
      bus8.in_select    = 4'(sel);
      bus8.in_data      = 8'(data);
      bus8.inc          = 1'($urandom_range(0, 1));
      bus8.dec          = 1'($urandom_range(0, 1));
      bus8.inc_select   = 3'(isel);
      bus8.out_a_select = 4'($urandom_range(0, 15));
      bus8.out_b_select = 4'($urandom_range(0, 15));
      #1;
      checkOutput("rand out_a", 32'(bus8.out_a), 32'(modelReg[bus8.out_a_select]));
      checkOutput("rand out_b", 32'(bus8.out_b), 32'(modelReg[bus8.out_b_select]));
      checkOutput("rand out_c", 32'(bus8.out_c),
                  32'(modelReg[2*isel+1] * 256 + modelReg[2*isel]));
      checkOutput("rand wrap", 32'(bus8.wrap), 32'(modelWrap));
      modelEdge(rst, bus8.write_en, sel, data, bus8.inc, bus8.dec, isel);
      tick();
    end

    rst = 1'b0;
    idle8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_ptr.md
# regfile_ptr

Parametrised general-purpose register file for the tinySoC CPU datapath, with two combinational read ports, one synchronous write port and a pointer port. The pointer port increments or decrements an adjacent register pair as a single 2×WIDTH-bit pointer. A registered wrap flag reports pointer overflow and underflow. The block feeds the ALU operands (out_a, out_b) and the memory address path (out_c).

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- DEPTH, 16, number of registers; power of two, ≥ 2
- AW, $clog2(DEPTH), register index width (derived, not overridden)
- PW, AW-1 (min 1), pair index width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- in_select  in  AW  write target register
- in_data  in  WIDTH  write data
- write_en  in  1  write strobe
- out_a_select  in  AW  read port A index
- out_b_select  in  AW  read port B index
- out_a  out  WIDTH  register[out_a_select], combinational
- out_b  out  WIDTH  register[out_b_select], combinational
- inc_select  in  PW  pointer pair index p (low = reg 2p, high = reg 2p+1)
- inc  in  1  increment pair p by 1
- dec  in  1  decrement pair p by 1
- out_c  out  2×WIDTH  {reg[2p+1], reg[2p]}, combinational
- wrap  out  1  registered; 1 for one cycle after a pointer wrap

## Operation
- Storage: DEPTH × WIDTH flops. No hardwired-zero register.
- Reads are combinational. They return the pre-edge contents, with no write-through bypass.
- Write: if write_en, then reg[in_select] ← in_data at the edge.
- Pointer operation, op = inc XOR dec:
  - inc=1, dec=0: pair ← pair + 1, mod 2^(2×WIDTH).
  - dec=1, inc=0: pair ← pair − 1, mod 2^(2×WIDTH).
  - inc=dec=1 or inc=dec=0: no pointer change, and wrap ← 0.
- Carry and borrow propagate from the low register into the high register. Example: 0x00FF + 1 = 0x0100.
- Wrap rules:
  - wrap ← 1 when an increment takes the pair from all-ones to 0.
  - wrap ← 1 when a decrement takes the pair from 0 to all-ones.
  - Otherwise wrap ← 0.
- Conflict rule: if write_en targets reg 2p or 2p+1 in the same cycle as a valid pointer op on pair p, the write wins.
  - The whole pointer op is suppressed; the other register of the pair is unchanged.
  - wrap ← 0.
- A write to a register outside the selected pair proceeds concurrently with the pointer op.
- Reset (rst=1 at an edge) overrides everything:
  - All registers ← 0 and wrap ← 0.
  - Any write or pointer op requested in that cycle is discarded.

## Timing
- Read latency: 0 cycles (combinational from the select inputs and state).
- Write and pointer latency: the result is visible on out_a, out_b and out_c in the cycle after the edge.
- wrap asserts in the cycle after the wrapping edge, for exactly one cycle unless the next op also wraps.
- Reset values: every register = 0, out_a = out_b = 0, out_c = 0, wrap = 0.
- Reset asserted mid-sequence (for example between two incs) clears everything at that edge. The operation resumes from 0 at the first edge with rst=0.
- No handshake: every valid request completes in one cycle, with no stall.

## Structure
- Shared package tinysoc_pkg holds:
  - the constant REG_COUNT_DEFAULT = 16;
  - the typedef ptr_op_e {PTR_NOP, PTR_INC, PTR_DEC}, decoded from inc/dec.
- Sub-module ptr_incdec, purely combinational:
  - inputs: 2×WIDTH value, ptr_op_e;
  - outputs: next value, wrap.
- The register array, conflict logic and wrap flop stay in regfile_ptr.
- Target size: about 150–250 lines including ptr_incdec.

## Test plan
1. Reset, then write 0xA5 to r3 and 0x5A to r7, select A=3, B=7 → out_a=0xA5, out_b=0x5A. In the same cycle as the write, out_a still shows 0x00.
2. Pair 1 = {r3,r2} = 0x00FF, inc=1 for 1 cycle → out_c=0x0100, wrap=0. Then dec=1 for 2 cycles → 0x00FE.
3. Pair 0 = 0xFFFF, inc=1 → out_c=0x0000 and wrap=1 for one cycle. Then dec=1 → out_c=0xFFFF and wrap=1. Then inc=dec=1 → value unchanged, wrap=0.
4. Pair 2 = 0x1234, in the same cycle inc=1 and write 0x77 to r4 → out_c=0x1277. Repeat with the write to r9 → out_c=0x1235 and r9=0x77.
5. Pair 0 incremented 3 times from 0, rst=1 on the 2nd edge → after reset out_c=0x0000; after the 3rd edge with rst=0 and inc=1 → 0x0001.
6. Parameters WIDTH=4, DEPTH=4: pair 1 = 0xFF, inc → 0x00, wrap=1. Write to index 3 is read back on out_b.
